// File: rtl/wb_result_sel_pipe_if.sv
// -----------------------------------------------------------------------------
// wb_result_sel_pipe_if
// Bundle of the upstream (beat in) and downstream (result out) handshakes of
// the writeback result selector.
//
// Parameters
//   WIDTH    datapath width
//   NUM_SRC  number of selectable sources (2..16)
//
// Signals
//   in_valid / in_ready          upstream handshake
//   src[NUM_SRC*WIDTH]           packed sources, source i at src[i*WIDTH +: WIDTH]
//   sel[SEL_W]                   source index
//   rd_in[5], we_in              destination register and write enable
//   funct3[3], addr_lo[2]        load type and byte offset (LOAD_EXT_EN only)
//   out_valid / out_ready        downstream handshake
//   result[WIDTH], rd_out[5]     selected value and destination register
//   we_out, sel_err              qualified write enable and bad-select flag
//
// Modports
//   master  the environment: drives beats in and the downstream ready
//   slave   the selector stage itself
//
// Optional feature macro: LOAD_EXT_EN (adds funct3 / addr_lo).
// -----------------------------------------------------------------------------
interface wb_result_sel_pipe_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic                     in_valid;
  logic                     in_ready;
  logic [NUM_SRC*WIDTH-1:0] src;
  logic [SEL_W-1:0]         sel;
  logic [4:0]               rd_in;
  logic                     we_in;
`ifdef LOAD_EXT_EN
  logic [2:0]               funct3;
  logic [1:0]               addr_lo;
`endif
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         result;
  logic [4:0]               rd_out;
  logic                     we_out;
  logic                     sel_err;

`ifdef LOAD_EXT_EN
  modport master (
    output in_valid, src, sel, rd_in, we_in, funct3, addr_lo, out_ready,
    input  in_ready, out_valid, result, rd_out, we_out, sel_err
  );

  modport slave (
    input  in_valid, src, sel, rd_in, we_in, funct3, addr_lo, out_ready,
    output in_ready, out_valid, result, rd_out, we_out, sel_err
  );
`else
  modport master (
    output in_valid, src, sel, rd_in, we_in, out_ready,
    input  in_ready, out_valid, result, rd_out, we_out, sel_err
  );

  modport slave (
    input  in_valid, src, sel, rd_in, we_in, out_ready,
    output in_ready, out_valid, result, rd_out, we_out, sel_err
  );
`endif

endinterface

// File: rtl/wb_result_sel_pipe.sv
// -----------------------------------------------------------------------------
// wb_result_sel_pipe
// Writeback result selector for the pipelined rv32i core, placed between MEM
// and the register file. Picks one of NUM_SRC sources, carries rd / we with
// it, and presents the beat through a registered output stage backed by a
// one-entry skid register so that in_ready never depends on out_ready.
//
// Default source map: 0 ALUResult, 1 ReadData, 2 PCPlus4, 3 ImmExt,
// 4 PCTarget (AUIPC).
//
// Ports
//   clk     in  rising-edge clock
//   rst_n   in  asynchronous active-low reset
//   bus     slave modport of wb_result_sel_pipe_if carrying both handshakes,
//           the packed sources, select, rd/we and the registered results
//
// Optional feature macro: LOAD_EXT_EN
//   When defined, source 1 (ReadData) is sign/zero extended according to
//   funct3 and addr_lo before selection. Requires WIDTH >= 32.
// -----------------------------------------------------------------------------
module wb_result_sel_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_result_sel_pipe_if.slave  bus
);

  localparam int SEL_W  = $clog2(NUM_SRC);
  localparam int SEL_N  = 2 ** SEL_W;
  localparam logic [SEL_W:0] NUM_SRC_W = NUM_SRC[SEL_W:0];

  // One beat as it travels through the output and skid registers.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       rd;
    logic             we;
    logic             err;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

`ifdef LOAD_EXT_EN
  // RV32I load extension of a fetched word: pick byte/half by offset, then
  // sign- or zero-extend. Unknown funct3 codes return the raw word.
  function automatic logic [WIDTH-1:0] load_ext(
    input logic [WIDTH-1:0] word,
    input logic [2:0]       f3,
    input logic [1:0]       lo
  );
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lo[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (f3)
      3'b000:  load_ext = {{(WIDTH-8){b[7]}}, b};
      3'b001:  load_ext = {{(WIDTH-16){h[15]}}, h};
      3'b100:  load_ext = {{(WIDTH-8){1'b0}}, b};
      3'b101:  load_ext = {{(WIDTH-16){1'b0}}, h};
      default: load_ext = word;
    endcase
  endfunction
`endif

  state_t           state_r;
  state_t           state_next_s;
  logic             in_ready_r;
  logic             out_valid_r;
  beat_t            out_beat_r;
  beat_t            skid_beat_r;
  beat_t            in_beat_s;
  logic             bad_sel_s;
  logic             accept_s;
  logic             drain_s;
  logic             load_out_in_s;
  logic             load_out_skid_s;
  logic             load_skid_s;
  logic [WIDTH-1:0] src_arr_s [SEL_N];

  assign accept_s = bus.in_valid & in_ready_r;
  assign drain_s  = out_valid_r & bus.out_ready;

  // Unpack sources into a power-of-two table; unused slots read as zero so an
  // out-of-range select naturally yields result 0.
  always_comb begin
    for (int i = 0; i < SEL_N; i++) begin
      src_arr_s[i] = {WIDTH{1'b0}};
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      src_arr_s[i] = bus.src[i*WIDTH +: WIDTH];
    end
`ifdef LOAD_EXT_EN
    src_arr_s[1] = load_ext(bus.src[WIDTH +: WIDTH], bus.funct3, bus.addr_lo);
`endif
  end

  // Form the incoming beat: selected value, qualified write enable, error flag.
  always_comb begin
    bad_sel_s      = ({1'b0, bus.sel} >= NUM_SRC_W);
    in_beat_s.data = src_arr_s[bus.sel];
    in_beat_s.rd   = bus.rd_in;
    in_beat_s.err  = bad_sel_s;
    // x0 is hardwired; a bad select must never corrupt the register file.
    in_beat_s.we   = bus.we_in & (bus.rd_in != 5'd0) & ~bad_sel_s;
  end

  // Next-state and register-load decode of the output/skid FSM.
  always_comb begin
    state_next_s    = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          load_out_in_s = 1'b1;
          state_next_s  = ST_FULL;
        end else begin
          state_next_s  = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (accept_s && drain_s) begin
          load_out_in_s = 1'b1;
          state_next_s  = ST_FULL;
        end else if (accept_s) begin
          load_skid_s   = 1'b1;
          state_next_s  = ST_SKID;
        end else if (drain_s) begin
          state_next_s  = ST_EMPTY;
        end else begin
          state_next_s  = ST_FULL;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only a drain can move us.
        if (drain_s) begin
          load_out_skid_s = 1'b1;
          state_next_s    = ST_FULL;
        end else begin
          state_next_s    = ST_SKID;
        end
      end
      default: begin
        state_next_s = ST_EMPTY;
      end
    endcase
  end

  // State register plus registered handshake outputs derived from next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != ST_EMPTY);
      in_ready_r  <= (state_next_s != ST_SKID);
    end
  end

  // Output beat register: loads from input or from skid, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_beat_r <= '{data: {WIDTH{1'b0}}, rd: 5'd0, we: 1'b0, err: 1'b0};
    end else if (load_out_in_s) begin
      out_beat_r <= in_beat_s;
    end else if (load_out_skid_s) begin
      out_beat_r <= skid_beat_r;
    end else begin
      out_beat_r <= out_beat_r;
    end
  end

  // Skid register: captures the beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_beat_r <= '{data: {WIDTH{1'b0}}, rd: 5'd0, we: 1'b0, err: 1'b0};
    end else if (load_skid_s) begin
      skid_beat_r <= in_beat_s;
    end else begin
      skid_beat_r <= skid_beat_r;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = out_beat_r.data;
  assign bus.rd_out    = out_beat_r.rd;
  assign bus.we_out    = out_beat_r.we;
  assign bus.sel_err   = out_beat_r.err;

endmodule

// File: tb/tb_wb_result_sel_pipe.sv
// -----------------------------------------------------------------------------
// tb_wb_result_sel_pipe
// Directed self-checking bench for wb_result_sel_pipe (WIDTH=32, NUM_SRC=5).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_wb_result_sel_pipe;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_result_sel_pipe_if #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) bus ();

  wb_result_sel_pipe #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [2:0] s, input logic [4:0] rd, input logic we);
    bus.in_valid = v;
    bus.sel      = s;
    bus.rd_in    = rd;
    bus.we_in    = we;
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    bus.src[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic test_reset();
    bus.src       = '0;
    bus.out_ready = 1'b1;
`ifdef LOAD_EXT_EN
    bus.funct3  = 3'b010;
    bus.addr_lo = 2'd0;
`endif
    set_beat(1'b0, 3'd0, 5'd0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.we_out !== 1'b0 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b r=%h we=%b err=%b want 0 0 0 0",
               bus.out_valid, bus.result, bus.we_out, bus.sel_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      set_beat(1'b1, k[2:0], 5'(k + 1), 1'b1);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== (32'h100 + k) || bus.rd_out !== 5'(k + 1)
          || bus.we_out !== 1'b1 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream_beat%0d got v=%b r=%h rd=%0d we=%b rdy=%b want 1 %h %0d 1 1",
                 k, bus.out_valid, bus.result, bus.rd_out, bus.we_out, bus.in_ready, 32'h100 + k, k + 1);
      end
    end
    set_beat(1'b0, 3'd3, 5'd9, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain got out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    set_src(0, 32'hA);
    set_beat(1'b1, 3'd0, 5'd1, 1'b1);
    tick();                                   // A accepted into output
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hA || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a_load got v=%b r=%h rdy=%b want 1 0000000a 1", bus.out_valid, bus.result, bus.in_ready);
    end
    set_src(0, 32'hB);
    set_beat(1'b1, 3'd0, 5'd2, 1'b1);
    tick();                                   // B goes to skid
    checks++;
    if (bus.result !== 32'hA || bus.rd_out !== 5'd1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_b_skid got r=%h rd=%0d rdy=%b want 0000000a 1 0", bus.result, bus.rd_out, bus.in_ready);
    end
    set_src(0, 32'hC);
    set_beat(1'b1, 3'd0, 5'd3, 1'b1);
    tick();                                   // C must wait
    checks++;
    if (bus.result !== 32'hA || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_c_wait got r=%h v=%b rdy=%b want 0000000a 1 0", bus.result, bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    tick();                                   // A drained, B moves up
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hB || bus.rd_out !== 5'd2 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_deliver_b got v=%b r=%h rd=%0d rdy=%b want 1 0000000b 2 1",
               bus.out_valid, bus.result, bus.rd_out, bus.in_ready);
    end
    tick();                                   // C accepted as B drains
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'hC || bus.rd_out !== 5'd3) begin
      errors++;
      $display("FAIL bp_deliver_c got v=%b r=%h rd=%0d want 1 0000000c 3", bus.out_valid, bus.result, bus.rd_out);
    end
    set_beat(1'b0, 3'd0, 5'd0, 1'b0);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_empty got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_x0_guard();
    bus.out_ready = 1'b1;
    set_src(0, 32'hDEADBEEF);
    set_beat(1'b1, 3'd0, 5'd0, 1'b1);
    tick();
    checks++;
    if (bus.we_out !== 1'b0 || bus.result !== 32'hDEADBEEF || bus.rd_out !== 5'd0) begin
      errors++;
      $display("FAIL x0_write got we=%b r=%h rd=%0d want 0 deadbeef 0", bus.we_out, bus.result, bus.rd_out);
    end
    set_beat(1'b1, 3'd0, 5'd5, 1'b1);
    tick();
    checks++;
    if (bus.we_out !== 1'b1 || bus.rd_out !== 5'd5) begin
      errors++;
      $display("FAIL x5_write got we=%b rd=%0d want 1 5", bus.we_out, bus.rd_out);
    end
    set_beat(1'b1, 3'd0, 5'd5, 1'b0);
    tick();
    checks++;
    if (bus.we_out !== 1'b0) begin
      errors++;
      $display("FAIL we_low got we=%b want 0", bus.we_out);
    end
  endtask

  task automatic test_bad_sel();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 32'h5A00 + i);
    set_beat(1'b1, 3'd7, 5'd3, 1'b1);
    tick();
    checks++;
    if (bus.result !== 32'h0 || bus.we_out !== 1'b0 || bus.sel_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_sel7 got r=%h we=%b err=%b want 00000000 0 1", bus.result, bus.we_out, bus.sel_err);
    end
    set_beat(1'b1, 3'd5, 5'd3, 1'b1);
    tick();
    checks++;
    if (bus.result !== 32'h0 || bus.we_out !== 1'b0 || bus.sel_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_sel5 got r=%h we=%b err=%b want 00000000 0 1", bus.result, bus.we_out, bus.sel_err);
    end
    set_beat(1'b1, 3'd2, 5'd3, 1'b1);
    tick();
    checks++;
    if (bus.result !== 32'h5A02 || bus.we_out !== 1'b1 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL good_sel2 got r=%h we=%b err=%b want 00005a02 1 0", bus.result, bus.we_out, bus.sel_err);
    end
    set_beat(1'b1, 3'd4, 5'd7, 1'b1);
    tick();
    checks++;
    if (bus.result !== 32'h5A04 || bus.sel_err !== 1'b0) begin
      errors++;
      $display("FAIL good_sel4 got r=%h err=%b want 00005a04 0", bus.result, bus.sel_err);
    end
    set_beat(1'b0, 3'd7, 5'd0, 1'b1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_sel got v=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_midstream();
    bus.out_ready = 1'b0;
    set_src(0, 32'h55);
    set_beat(1'b1, 3'd0, 5'd4, 1'b1);
    tick();
    set_beat(1'b1, 3'd0, 5'd6, 1'b1);
    tick();                                   // output + skid both full
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h55) begin
      errors++;
      $display("FAIL mid_preload got v=%b r=%h want 1 00000055", bus.out_valid, bus.result);
    end
    set_beat(1'b0, 3'd0, 5'd0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.we_out !== 1'b0 || bus.rd_out !== 5'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b r=%h we=%b rd=%0d want 0 00000000 0 0",
               bus.out_valid, bus.result, bus.we_out, bus.rd_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got rdy=%b v=%b want 1 0 (skid beat dropped)", bus.in_ready, bus.out_valid);
    end
  endtask

`ifdef LOAD_EXT_EN
  task automatic test_load_ext();
    logic [2:0]  f3_tab [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  lo_tab [4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ex_tab [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h000080FF};
    bus.out_ready = 1'b1;
    set_src(1, 32'h80FF7F80);
    for (int k = 0; k < 4; k++) begin
      bus.funct3  = f3_tab[k];
      bus.addr_lo = lo_tab[k];
      set_beat(1'b1, 3'd1, 5'd8, 1'b1);
      tick();
      checks++;
      if (bus.result !== ex_tab[k]) begin
        errors++;
        $display("FAIL load_ext%0d got r=%h want %h", k, bus.result, ex_tab[k]);
      end
    end
    bus.funct3 = 3'b010;
    set_beat(1'b0, 3'd0, 5'd0, 1'b0);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_x0_guard();
    test_bad_sel();
    test_reset_midstream();
`ifdef LOAD_EXT_EN
    test_load_ext();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
